// File: rtl/interp_pkg.sv
// interp_pkg: shared widths, FSM state encoding and out_idx codes for the interpolation register reader.
package interp_pkg;
    localparam int REG1_DEF  = 17;
    localparam int REG2_DEF  = 18;
    localparam int REG3_DEF  = 20;
    localparam int OUT_W_DEF = 16;
    // The three beats share one EMIT state; out_idx tells them apart, so 3 bits cover the sequence.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_H6,
        ST_WR_2H6,
        ST_WR_5H9,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_e;
    localparam logic [1:0] IDX_H6  = 2'd0;
    localparam logic [1:0] IDX_2H6 = 2'd1;
    localparam logic [1:0] IDX_5H9 = 2'd2;
endpackage

// File: rtl/interp_narrow.sv
// interp_narrow: combinational signed width conversion from IN_W to OUT_W.
// Ports: in_i (IN_W, signed) -> out_o (OUT_W, signed).
// Widening sign-extends. Narrowing wraps (keeps the OUT_W LSBs) by default,
// or saturates to the OUT_W signed range when INTERP_SAT_EN is defined.
module interp_narrow #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);
    if (IN_W <= OUT_W) begin : g_ext
        assign out_o = OUT_W'(in_i);
    end else begin : g_narrow
`ifdef INTERP_SAT_EN
        logic fits;
        // The value fits when every bit from the OUT_W sign position upward equals the sign.
        assign fits  = (&in_i[IN_W-1:OUT_W-1]) | ~(|in_i[IN_W-1:OUT_W-1]);
        assign out_o = fits ? in_i[OUT_W-1:0] : {in_i[IN_W-1], {(OUT_W-1){~in_i[IN_W-1]}}};
`else
        logic unused_hi;
        assign unused_hi = ^in_i[IN_W-1:OUT_W];
        assign out_o     = in_i[OUT_W-1:0];
`endif
    end
endmodule

// File: rtl/interp_reg_reader.sv
// interp_reg_reader: strobes the h6/2h6/5h9 bank writes in order, settles, then streams the three read-backs.
// Ports: clk, rst (async active-low), start, flush (sync abort), reg_h6/reg_2h6/reg_5h9 (bank outputs),
//        en_reg_h6/en_reg_2h6/en_reg_5h9 (bank strobes), out_data/out_idx/out_valid/out_ready (stream),
//        busy (not IDLE), done (one-cycle pulse after the last beat).
// Build option: INTERP_SAT_EN selects saturating narrowing inside interp_narrow (default wraps).
module interp_reg_reader
    import interp_pkg::*;
#(
    parameter int REG1  = REG1_DEF,
    parameter int REG2  = REG2_DEF,
    parameter int REG3  = REG3_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic signed [REG1-1:0]  reg_h6,
    input  logic signed [REG2-1:0]  reg_2h6,
    input  logic signed [REG3-1:0]  reg_5h9,
    output logic                    en_reg_h6,
    output logic                    en_reg_2h6,
    output logic                    en_reg_5h9,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);
    state_e                  state_q;
    logic [2:0]              en_q;
    logic signed [OUT_W-1:0] data_q;
    logic [1:0]              idx_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [OUT_W-1:0] n_h6;
    logic signed [OUT_W-1:0] n_2h6;
    logic signed [OUT_W-1:0] n_5h9;

    interp_narrow #(.IN_W(REG1), .OUT_W(OUT_W)) u_nar_h6  (.in_i(reg_h6),  .out_o(n_h6));
    interp_narrow #(.IN_W(REG2), .OUT_W(OUT_W)) u_nar_2h6 (.in_i(reg_2h6), .out_o(n_2h6));
    interp_narrow #(.IN_W(REG3), .OUT_W(OUT_W)) u_nar_5h9 (.in_i(reg_5h9), .out_o(n_5h9));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            data_q  <= '0;
            idx_q   <= IDX_H6;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            data_q  <= '0;
            idx_q   <= IDX_H6;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WR_H6;
                        en_q    <= 3'b001;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WR_H6: begin
                    state_q <= ST_WR_2H6;
                    en_q    <= 3'b010;
                end
                ST_WR_2H6: begin
                    state_q <= ST_WR_5H9;
                    en_q    <= 3'b100;
                end
                ST_WR_5H9: begin
                    state_q <= ST_SETTLE;
                    en_q    <= '0;
                end
                ST_SETTLE: begin
                    state_q <= ST_EMIT;
                    valid_q <= 1'b1;
                    idx_q   <= IDX_H6;
                    data_q  <= n_h6;
                end
                ST_EMIT: begin
                    // Each accepted beat loads the next read-back so beats can go back to back.
                    if (out_ready) begin
                        if (idx_q == IDX_5H9) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 2'd1;
                            data_q <= (idx_q == IDX_H6) ? n_2h6 : n_5h9;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign en_reg_h6  = en_q[0];
    assign en_reg_2h6 = en_q[1];
    assign en_reg_5h9 = en_q[2];
    assign out_data   = data_q;
    assign out_idx    = idx_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_interp_reg_reader.sv
// tb_interp_reg_reader: randomized self-checking bench with a behavioural register bank and conversion model.
module tb_interp_reg_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [16:0] reg_h6 = '0;
    logic [17:0] reg_2h6 = '0;
    logic [19:0] reg_5h9 = '0;
    logic [16:0] nxt_h6 = '0;
    logic [17:0] nxt_2h6 = '0;
    logic [19:0] nxt_5h9 = '0;
    logic        en_reg_h6, en_reg_2h6, en_reg_5h9;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid, busy, done;
    logic [2:0]  en_v;
    int          checks = 0;
    int          failures = 0;

    interp_reg_reader dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .reg_h6(reg_h6), .reg_2h6(reg_2h6), .reg_5h9(reg_5h9),
        .en_reg_h6(en_reg_h6), .en_reg_2h6(en_reg_2h6), .en_reg_5h9(en_reg_5h9),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign en_v = {en_reg_5h9, en_reg_2h6, en_reg_h6};

    // Register bank: a strobe loads the value staged for that register.
    always @(posedge clk) begin
        if (en_reg_h6)  reg_h6  <= nxt_h6;
        if (en_reg_2h6) reg_2h6 <= nxt_2h6;
        if (en_reg_5h9) reg_5h9 <= nxt_5h9;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] conv(input longint v);
        logic [63:0] u;
`ifdef INTERP_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        u = v;
        return u[15:0];
    endfunction

    function automatic logic [31:0] rnd_val(input int w);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return (32'd1 << (w - 1)) - 32'd1;
            1:       return 32'hFFFF_FFFF << (w - 1);
            2:       return {{20{r[11]}}, r[11:0]};
            default: return r;
        endcase
    endfunction

    // mode 0: ready always high, 1: random ready and stray starts, 2: ready low 3 cycles on beat 1
    task automatic run_seq(input logic [16:0] a, input logic [17:0] b, input logic [19:0] c, input int mode);
        logic [15:0] exp_q [3];
        int k, n, s;
        logic r;
        nxt_h6  = a;
        nxt_2h6 = b;
        nxt_5h9 = c;
        exp_q[0] = conv(longint'($signed(a)));
        exp_q[1] = conv(longint'($signed(b)));
        exp_q[2] = conv(longint'($signed(c)));
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("strobe_h6", en_v, 3'b001);
        check("busy_wr", busy, 1'b1);
        tick();
        check("strobe_2h6", en_v, 3'b010);
        tick();
        check("strobe_5h9", en_v, 3'b100);
        tick();
        check("settle", {en_v, out_valid, done}, 5'b0);
        tick();
        k = 0;
        n = 0;
        s = 0;
        while (k < 3 && n < 64) begin
            check("valid", out_valid, 1'b1);
            check("idx", out_idx, k);
            check("data", out_data, exp_q[k]);
            check("no_strobe_emit", en_v, 3'b000);
            check("no_done_emit", done, 1'b0);
            r = (mode == 0) ? 1'b1 : (mode == 2) ? !(k == 1 && s < 3) : ($urandom_range(0, 2) != 0);
            if (!r) s++;
            if (mode == 1) start = 1'($urandom_range(0, 1));
            out_ready = r;
            tick();
            n++;
            if (r) k++;
        end
        check("beats", k, 3);
        check("beat_cycles", n, 3 + s);
        check("done", done, 1'b1);
        check("done_valid", out_valid, 1'b0);
        check("done_busy", busy, 1'b1);
        start = (mode == 1);
        out_ready = 1'b0;
        tick();
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_en", en_v, 3'b000);
        start = 1'b0;
        tick();
        check("start_in_done_ignored", {busy, en_v}, 4'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("reset_outs", {en_v, out_valid, busy, done, out_idx, out_data}, 0);
        rst = 1'b1;
        tick();
        check("idle_after_reset", {en_v, out_valid, busy, done}, 0);
        run_seq(17'h00123, 18'h3FFFF, 20'h7FFFF, 0);
        run_seq(17'h1FF00, 18'h00042, 20'h80000, 0);
        run_seq(17'(rnd_val(17)), 18'(rnd_val(18)), 20'(rnd_val(20)), 2);
        // flush while in WR_2H6, with start also asserted
        nxt_h6 = 17'(rnd_val(17));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("flush_pre_h6", en_v, 3'b001);
        tick();
        check("flush_pre_2h6", en_v, 3'b010);
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        check("flush_idle", {en_v, out_valid, done, busy}, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("flush_quiet", {en_v, out_valid, done, busy}, 0);
        end
        // start while busy, then async reset during EMIT0
        nxt_h6 = 17'h0ABCD;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", {out_valid, out_idx}, 3'b100);
        check("pre_rst_data", out_data, 16'hABCD);
        start = 1'b1;
        tick();
        check("busy_start_ignored", {out_valid, out_idx, en_v}, 6'b100000);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {en_v, out_valid, busy, done, out_idx, out_data}, 0);
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", {en_v, out_valid, busy, done, out_idx, out_data}, 0);
        for (int i = 0; i < 40; i++)
            run_seq(17'(rnd_val(17)), 18'(rnd_val(18)), 20'(rnd_val(20)), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
